// File: rtl/cla_sub32_pipe_pkg.sv
// cla_sub32_pipe_pkg: shared width, result type and 4-bit lookahead helpers
package cla_sub32_pipe_pkg;
  localparam int WIDTH_DEF = 32;
  typedef struct packed {
    logic [WIDTH_DEF-1:0] diff;
    logic                 bout;
    logic                 ovf;
    logic                 zero;
  } res_t;
  // {group generate, group propagate} of a 4-bit group
  function automatic logic [1:0] gp4(input logic [3:0] g, input logic [3:0] p);
    return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p};
  endfunction
  // carries into bits 3..0 of a 4-bit group, flattened sum-of-products
  function automatic logic [3:0] carry4(input logic [2:0] g, input logic [2:0] p, input logic ci);
    return {g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci),
            g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci),
            g[0] | (p[0] & ci),
            ci};
  endfunction
endpackage

// File: rtl/cla_sub32_pipe_cla16.sv
// cla16_slice: 16-bit two-level carry-lookahead adder slice (four 4-bit groups)
module cla16_slice
  import cla_sub32_pipe_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co,
  output logic        G,
  output logic        P
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp, gc;
  assign g = x & y;
  assign p = x ^ y;
  for (genvar i = 0; i < 4; i++) begin : g_grp
    assign {gg[i], gp[i]} = gp4(g[4*i+:4], p[4*i+:4]);
    assign c[4*i+:4] = carry4(g[4*i+:3], p[4*i+:3], gc[i]);
  end
  // second-level lookahead over the four groups
  assign gc = carry4(gg[2:0], gp[2:0], ci);
  assign {G, P} = gp4(gg, gp);
  assign co = G | (P & ci);
  assign s = p ^ c;
endmodule

// File: rtl/cla_sub32_pipe.sv
// cla_sub32_pipe: two-stage pipelined CLA subtractor, diff = a - b - bin on a valid/ready stream
module cla_sub32_pipe
  import cla_sub32_pipe_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);
  localparam int HW = WIDTH / 2;
  logic          s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic          s1_en, s2_en, s1_pop;
  logic [HW-1:0] lo_s, hi_s, lo_q, ahi_q, nbhi_q;
  logic          lo_co, hi_co, c16_q, amsb_q, bmsb_q;
  logic          g_lo, p_lo, g_hi, p_hi, unused_gp;
  res_t          res_c, res_q, res_o;
  cla16_slice u_lo (
    .x  (a[HW-1:0]),
    .y  (~b[HW-1:0]),
    .ci (~bin),
    .s  (lo_s),
    .co (lo_co),
    .G  (g_lo),
    .P  (p_lo)
  );
  cla16_slice u_hi (
    .x  (ahi_q),
    .y  (nbhi_q),
    .ci (c16_q),
    .s  (hi_s),
    .co (hi_co),
    .G  (g_hi),
    .P  (p_hi)
  );
  assign unused_gp = ^{g_lo, p_lo, g_hi, p_hi};
  assign res_c = {{hi_s, lo_q}, ~hi_co, (amsb_q ^ bmsb_q) & (hi_s[HW-1] ^ amsb_q), ~|{hi_s, lo_q}};
  // stage 1 drains into stage 2, or straight to the consumer when unregistered
  always_comb begin
    s2_en      = s1_valid_q & (~s2_valid_q | out_ready);
    s1_pop     = s1_valid_q & (REG_OUT ? s2_en : out_ready);
    in_ready   = ~s1_valid_q | s1_pop;
    s1_en      = in_valid & in_ready;
    s1_valid_d = s1_en | (s1_valid_q & ~s1_pop);
    s2_valid_d = REG_OUT & (s2_en | (s2_valid_q & ~out_ready));
    out_valid  = REG_OUT ? s2_valid_q : s1_valid_q;
    res_o      = REG_OUT ? res_q : (s1_valid_q ? res_c : '0);
  end
  assign {diff, bout, ovf, zero} = res_o;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      lo_q       <= '0;
      ahi_q      <= '0;
      nbhi_q     <= '0;
      c16_q      <= 1'b0;
      amsb_q     <= 1'b0;
      bmsb_q     <= 1'b0;
      res_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_en) begin
        lo_q   <= lo_s;
        c16_q  <= lo_co;
        ahi_q  <= a[WIDTH-1:HW];
        nbhi_q <= ~b[WIDTH-1:HW];
        amsb_q <= a[WIDTH-1];
        bmsb_q <= b[WIDTH-1];
      end
      if (s2_en) res_q <= res_c;
    end
endmodule

// File: tb/tb_cla_sub32_pipe.sv
// tb_cla_sub32_pipe: directed checks of the pipelined subtractor, incl. backpressure and async reset
module tb_cla_sub32_pipe;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, bin, out_valid, out_ready, bout, ovf, zero;
  logic [31:0] a, b, diff;
  int          checks = 0;
  int          errors = 0;
  logic [64:0] vec [8] = '{
    {32'h12345678, 32'h87654321, 1'b0},
    {32'hFFFFFFFF, 32'h00000001, 1'b1},
    {32'h0000FFFF, 32'h00010000, 1'b0},
    {32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0},
    {32'hDEADBEEF, 32'hDEADBEEF, 1'b0},
    {32'h00008000, 32'h00008000, 1'b1},
    {32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1},
    {32'h00000000, 32'h80000000, 1'b0}
  };

  cla_sub32_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] model(input logic [64:0] v);
    logic [32:0] r;
    logic [31:0] x, y;
    x = v[64:33];
    y = v[32:1];
    r = {1'b0, x} - {1'b0, y} - {32'd0, v[0]};
    return {r[31:0], r[32], (x[31] != y[31]) && (r[31] != x[31]), r[31:0] == 32'd0};
  endfunction

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one isolated transaction: accept, one cycle in flight, result visible, consumed
  task automatic single(input string tag, input logic [64:0] v, input logic [34:0] exp);
    {a, b, bin} = v;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, 35'(in_ready), 35'(1));
    @(negedge clk);
    in_valid = 1'b0;
    {a, b, bin} = ~v;
    #1 chk({tag, "_lat"}, 35'(out_valid), 35'(0));
    @(negedge clk);
    chk({tag, "_ov"}, 35'(out_valid), 35'(1));
    chk(tag, {diff, bout, ovf, zero}, exp);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  pat;
    logic [34:0] prev;
    logic        stalled;
    int          tx, rx;
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    {a, b, bin} = {32'h11111111, 32'h22222222, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_ov", 35'(out_valid), 35'(0));
    chk("rst_out", {diff, bout, ovf, zero}, 35'(0));
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("rst_rdy", 35'(in_ready), 35'(1));

    single("basic", {32'h001F001F, 32'h000C001F, 1'b0}, {32'h00130000, 3'b000});
    single("wrap", {32'h00000000, 32'h00000001, 1'b0}, {32'hFFFFFFFF, 3'b100});
    single("sovf", {32'h80000000, 32'h00000001, 1'b0}, {32'h7FFFFFFF, 3'b010});
    single("binz", {32'h0000001F, 32'h0000001E, 1'b1}, {32'h00000000, 3'b001});
    single("eqbin", {32'hFFC007FF, 32'hFFC007FF, 1'b1}, {32'hFFFFFFFF, 3'b100});
    chk("idle_ov", 35'(out_valid), 35'(0));

    pat = 4'b1001;
    tx = 0;
    rx = 0;
    stalled = 1'b0;
    prev = '0;
    for (int cyc = 0; cyc < 100 && rx < 8; cyc++) begin
      out_ready = pat[cyc % 4];
      in_valid = (tx < 8);
      if (tx < 8) {a, b, bin} = vec[tx];
      #1;
      if (stalled) begin
        chk("hold_ov", 35'(out_valid), 35'(1));
        chk("hold", {diff, bout, ovf, zero}, prev);
      end
      chk("bp_rdy", 35'(in_ready), 35'(!((tx - rx == 2) && !out_ready)));
      if (out_valid && out_ready) begin
        chk($sformatf("stream%0d", rx), {diff, bout, ovf, zero}, model(vec[rx]));
        rx++;
      end
      stalled = out_valid && !out_ready;
      prev = {diff, bout, ovf, zero};
      if (in_valid && in_ready) tx++;
      @(negedge clk);
    end
    chk("stream_count", 35'(rx), 35'(8));
    chk("drain_ov", 35'(out_valid), 35'(0));

    out_ready = 1'b0;
    in_valid = 1'b1;
    {a, b, bin} = vec[0];
    @(negedge clk);
    {a, b, bin} = vec[1];
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_ov", 35'(out_valid), 35'(1));
    chk("full_rdy", 35'(in_ready), 35'(0));
    #2 rst_n = 1'b0;
    #1 chk("arst_ov", 35'(out_valid), 35'(0));
    chk("arst_out", {diff, bout, ovf, zero}, 35'(0));
    @(negedge clk);
    rst_n = 1'b1;
    single("post_rst", vec[6], model(vec[6]));
    chk("post_rst_idle", 35'(out_valid), 35'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_sub32_pipe.md
Name: cla_sub32_pipe

Overview:
- Two-stage pipelined 32-bit carry-lookahead subtractor. It computes diff = a - b - bin.
- It is the inverse-direction companion to the team's combinational 32-bit CLA adder.
- Arithmetic is a + ~b + ~bin through two 16-bit CLA slices, with a register between the slices.
- Sits on a valid/ready stream so datapath blocks can issue back-to-back subtractions at full clock rate with backpressure.

Parameters:
- WIDTH, 32, operand width; must be even. Low slice is WIDTH/2 bits, high slice is WIDTH/2 bits.
- REG_OUT, 1, 1 = stage-2 result registered (latency 2); 0 = stage-2 result combinational from the stage-1 register (latency 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a, b, bin valid this cycle.
- in_ready  output  1  block accepts the operands this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  diff and flags valid.
- out_ready  input  1  consumer accepts the result this cycle.
- diff  output  WIDTH  a - b - bin, mod 2^WIDTH.
- bout  output  1  borrow-out: 1 iff unsigned a < b + bin.
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].
- zero  output  1  diff == 0.

Behaviour:
- Reset: asynchronous, active-low.
  - While rst_n is low: s1_valid=0, s2_valid=0, out_valid=0, diff=0, bout=0, ovf=0, zero=0, and all data registers cleared.
  - in_ready is 1 once out of reset.
  - Reset asserted mid-operation drops all in-flight results with no partial output.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Stage 1, registered on input transfer:
  - low slice computes a[15:0] + ~b[15:0] + ~bin;
  - registers low diff, low carry-out c16, a_hi, ~b_hi, and a[MSB], b[MSB].
- Stage 2, registered when it advances:
  - high slice computes a_hi + ~b_hi + c16;
  - produces diff, bout = ~c32, ovf, zero.
- Advance rules (REG_OUT=1):
  - s2_en = s1_valid && (!s2_valid || out_ready).
  - s1_en = in_valid && (!s1_valid || s2_en).
  - in_ready = !s1_valid || s2_en.
- Throughput and latency: one result per cycle when out_ready is held high. First result is visible 2 cycles after the input transfer.
- Stall:
  - out_valid held with out_ready=0 → diff, bout, ovf, zero hold stable.
  - Stage 1 holds its contents; in_ready falls once both stages are full.
- Simultaneous events: output transfer and stage-1 advance in the same cycle is legal and required (no bubble).
- in_valid deasserted → bubbles propagate; out_valid falls after the last result drains.
- REG_OUT=0: out_valid = s1_valid; outputs are combinational from stage 1; in_ready = !s1_valid || out_ready.
- Width rules:
  - No result bits beyond WIDTH.
  - Wrap-around is defined: 0 - 1 = all-ones with bout=1.
  - a == b with bin=0 → diff=0, zero=1, bout=0.
- Inputs are sampled only on an input transfer; a and b may change freely otherwise.

Decomposition:
- Shared package holds:
  - the WIDTH default constant;
  - a result struct {diff, bout, ovf, zero};
  - a generate/propagate helper function for 4-bit lookahead groups, reused by the existing adder.
- One sub-module: cla16_slice.
  - Inputs: x[15:0], y[15:0], ci. Outputs: s[15:0], co, plus group generate G and propagate P.
  - Built from four 4-bit lookahead groups and a second-level lookahead unit.
  - Instantiated twice: the low slice before the register, the high slice after it.

Test Plan:
- Reset: rst_n=0 for 3 cycles with in_valid=1 → out_valid=0, diff=0, in_ready=1 after release.
- Basic subtraction: a=0x001F001F, b=0x000C001F, bin=0 → diff=0x00130000, bout=0, ovf=0, zero=0, two cycles after the input transfer.
- Wrap and borrow: a=0x00000000, b=0x00000001, bin=0 → diff=0xFFFFFFFF, bout=1, ovf=0.
  - Then a=0x80000000, b=0x00000001, bin=0 → diff=0x7FFFFFFF, bout=0, ovf=1.
- Borrow-in and zero:
  - a=0x0000001F, b=0x0000001E, bin=1 → diff=0, zero=1, bout=0.
  - a=b=0xFFC007FF, bin=1 → diff=0xFFFFFFFF, bout=1.
- Backpressure: stream 8 random operand sets with out_ready toggling 1,0,0,1,… → every result matches the reference model in order. No loss or duplication; outputs stable while stalled; in_ready=0 only when both stages are full.
- Reset mid-stream: assert rst_n=0 with 2 results in flight → out_valid=0 immediately (asynchronous); after release, the first new input yields only its own result.
